// File: rtl/cpu_sequencer_if.sv
// Bus bundle between the VeriRISC run-control sequencer and its environment:
// run control, core memory strobes, loader port and the shared memory side.
interface cpu_sequencer_if #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
);
    logic              run;
    logic              step;
    logic              halt;
    logic [AWIDTH-1:0] cpu_addr;
    logic [DWIDTH-1:0] cpu_wdata;
    logic              cpu_rd;
    logic              cpu_wr;
    logic              ld_req;
    logic              ld_we;
    logic [AWIDTH-1:0] ld_addr;
    logic [DWIDTH-1:0] ld_wdata;
    logic [2:0]        phase;
    logic              cpu_en;
    logic              ld_gnt;
    logic              halted;
    logic              busy;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;

    modport master (
        output run, step, halt, cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
               ld_req, ld_we, ld_addr, ld_wdata,
        input  phase, cpu_en, ld_gnt, halted, busy,
               mem_addr, mem_wdata, mem_rd, mem_wr
    );

    modport slave (
        input  run, step, halt, cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
               ld_req, ld_we, ld_addr, ld_wdata,
        output phase, cpu_en, ld_gnt, halted, busy,
               mem_addr, mem_wdata, mem_rd, mem_wr
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Run-control sequencer for the VeriRISC core: instruction phase generation,
// run/step/halt control and loader access to the shared memory at boundaries.
module cpu_sequencer #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    cpu_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_HALTED = 3'd3,
        ST_LOAD   = 3'd4
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [2:0] phase_r;
    logic [2:0] phase_s;
    logic       step_q_r;
    logic       halt_seen_r;
    logic       halt_seen_s;
    logic       exec_s;
    logic       boundary_s;
    logic       step_edge_s;
    logic       stop_s;

    assign exec_s      = (state_r == ST_RUN) || (state_r == ST_STEP);
    assign boundary_s  = exec_s && (phase_r == 3'd7);
    assign step_edge_s = bus.step & ~step_q_r;
    // halt may arrive in the boundary cycle itself, before halt_seen can latch it
    assign stop_s      = halt_seen_r | bus.halt;

    // Next-state, next-phase and halt-tracking decisions
    always_comb begin
        state_s     = state_r;
        phase_s     = 3'd0;
        halt_seen_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.ld_req)       state_s = ST_LOAD;
                else if (bus.run)     state_s = ST_RUN;
                else if (step_edge_s) state_s = ST_STEP;
                else                  state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (!boundary_s)      state_s = ST_RUN;
                else if (stop_s)      state_s = ST_HALTED;
                else if (bus.ld_req)  state_s = ST_LOAD;
                else if (!bus.run)    state_s = ST_IDLE;
                else                  state_s = ST_RUN;
            end
            ST_STEP: begin
                if (!boundary_s)      state_s = ST_STEP;
                else if (stop_s)      state_s = ST_HALTED;
                else                  state_s = ST_IDLE;
            end
            ST_HALTED: begin
                if (bus.ld_req)       state_s = ST_LOAD;
                else                  state_s = ST_HALTED;
            end
            ST_LOAD: begin
                if (!bus.ld_req)      state_s = ST_IDLE;
                else                  state_s = ST_LOAD;
            end
            default: state_s = ST_IDLE;
        endcase

        if (exec_s) phase_s = phase_r + 3'd1;
        else        phase_s = 3'd0;

        if ((state_s == ST_RUN) || (state_s == ST_STEP))
            halt_seen_s = halt_seen_r | (exec_s & bus.halt);
        else
            halt_seen_s = 1'b0;
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            phase_r     <= 3'd0;
            step_q_r    <= 1'b0;
            halt_seen_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            phase_r     <= phase_s;
            step_q_r    <= bus.step;
            halt_seen_r <= halt_seen_s;
        end
    end

    assign bus.phase  = phase_r;
    assign bus.cpu_en = exec_s;
    assign bus.busy   = exec_s;
    assign bus.halted = (state_r == ST_HALTED);
    assign bus.ld_gnt = (state_r == ST_LOAD);

    // Shared memory mux; a core write is dropped when it collides with a read
    always_comb begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        if (state_r == ST_LOAD) begin
            bus.mem_addr  = bus.ld_addr;
            bus.mem_wdata = bus.ld_wdata;
            bus.mem_rd    = bus.ld_req & ~bus.ld_we;
            bus.mem_wr    = bus.ld_req & bus.ld_we;
        end else begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_rd    = bus.cpu_rd & exec_s;
            bus.mem_wr    = bus.cpu_wr & exec_s & ~bus.cpu_rd;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios plus random traffic, every cycle
// compared against a behavioural run-control model.
module tb_cpu_sequencer;
    localparam int AW = 5;
    localparam int DW = 8;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;
    localparam int M_HALT = 3;
    localparam int M_LOAD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_sequencer_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    cpu_sequencer #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // model: activity mode, cycles done in current instruction, pending halt
    int m_mode = M_IDLE;
    int m_cyc  = 0;
    bit m_halt_pend = 1'b0;
    bit m_prev_step = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_exec();
        return (m_mode == M_RUN) || (m_mode == M_STEP);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_cyc = 0;
        m_halt_pend = 1'b0;
        m_prev_step = 1'b0;
    endtask

    task automatic model_step();
        bit ex;
        bit rise;
        bit stop;
        ex   = m_exec();
        rise = bus.step && !m_prev_step;
        stop = m_halt_pend || (ex && bus.halt);
        if (m_mode == M_IDLE) begin
            if (bus.ld_req)   m_mode = M_LOAD;
            else if (bus.run) m_mode = M_RUN;
            else if (rise)    m_mode = M_STEP;
        end else if (ex) begin
            if (m_cyc == 7) begin
                if (stop)                  m_mode = M_HALT;
                else if (m_mode == M_STEP) m_mode = M_IDLE;
                else if (bus.ld_req)       m_mode = M_LOAD;
                else if (!bus.run)         m_mode = M_IDLE;
                m_cyc = 0;
                m_halt_pend = 1'b0;
            end else begin
                m_cyc++;
                m_halt_pend = stop;
            end
        end else if (m_mode == M_HALT) begin
            if (bus.ld_req) m_mode = M_LOAD;
        end else if (m_mode == M_LOAD) begin
            if (!bus.ld_req) m_mode = M_IDLE;
        end
        m_prev_step = bus.step;
    endtask

    task automatic check_outputs();
        bit ex;
        ex = m_exec();
        check_val("phase", 32'(bus.phase), ex ? 32'(m_cyc) : 32'd0);
        check_val("cpu_en", 32'(bus.cpu_en), 32'(ex));
        check_val("busy", 32'(bus.busy), 32'(ex));
        check_val("halted", 32'(bus.halted), 32'(m_mode == M_HALT));
        check_val("ld_gnt", 32'(bus.ld_gnt), 32'(m_mode == M_LOAD));
        if (m_mode == M_LOAD) begin
            check_val("mem_addr_ld", 32'(bus.mem_addr), 32'(bus.ld_addr));
            check_val("mem_wdata_ld", 32'(bus.mem_wdata), 32'(bus.ld_wdata));
            check_val("mem_rd_ld", 32'(bus.mem_rd), 32'(bus.ld_req && !bus.ld_we));
            check_val("mem_wr_ld", 32'(bus.mem_wr), 32'(bus.ld_req && bus.ld_we));
        end else begin
            check_val("mem_addr_cpu", 32'(bus.mem_addr), 32'(bus.cpu_addr));
            check_val("mem_wdata_cpu", 32'(bus.mem_wdata), 32'(bus.cpu_wdata));
            check_val("mem_rd_cpu", 32'(bus.mem_rd), 32'(bus.cpu_rd && ex));
            check_val("mem_wr_cpu", 32'(bus.mem_wr), 32'(bus.cpu_wr && ex && !bus.cpu_rd));
        end
        check_val("rd_wr_excl", 32'(bus.mem_rd && bus.mem_wr), 32'd0);
    endtask

    // inputs are set at the falling edge; compare, then advance model across the rising edge
    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic tick_until_exec_phase(input int p, input string tag);
        int n;
        n = 0;
        while (!(m_exec() && m_cyc == p) && n < 40) begin
            tick();
            n++;
        end
        check_val({tag, "_reached"}, 32'(m_exec() && m_cyc == p), 32'd1);
    endtask

    task automatic tick_until_mode(input int mode, input string tag);
        int n;
        n = 0;
        while (m_mode != mode && n < 40) begin
            tick();
            n++;
        end
        check_val({tag, "_reached"}, 32'(m_mode), 32'(mode));
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_val({tag, "_phase"}, 32'(bus.phase), 32'd0);
        check_val({tag, "_cpu_en"}, 32'(bus.cpu_en), 32'd0);
        check_val({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_val({tag, "_halted"}, 32'(bus.halted), 32'd0);
        check_val({tag, "_ld_gnt"}, 32'(bus.ld_gnt), 32'd0);
        check_val({tag, "_mem_rd"}, 32'(bus.mem_rd), 32'd0);
        check_val({tag, "_mem_wr"}, 32'(bus.mem_wr), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        bus.ld_req = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.run = 1'b0;  bus.step = 1'b0;  bus.halt = 1'b0;
        bus.cpu_addr = '0;  bus.cpu_wdata = '0;  bus.cpu_rd = 1'b0;  bus.cpu_wr = 1'b0;
        bus.ld_req = 1'b0;  bus.ld_we = 1'b0;  bus.ld_addr = '0;  bus.ld_wdata = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // free run: three back-to-back instructions, then drop run
        bus.run = 1'b1;
        repeat (24) tick();
        bus.run = 1'b0;
        tick_until_mode(M_IDLE, "run_stop");

        // single step with step held high, then a second rising edge
        bus.step = 1'b1;
        repeat (20) tick();
        bus.step = 1'b0;
        tick();
        bus.step = 1'b1;
        repeat (12) tick();
        bus.step = 1'b0;
        tick();

        // halt at phase 3, run toggling ignored while halted, loader releases
        bus.run = 1'b1;
        tick_until_exec_phase(3, "halt_ph3");
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 6; i++) begin
            bus.run = ~bus.run;
            tick();
        end
        bus.run = 1'b1;
        bus.ld_req = 1'b1;
        bus.ld_we = 1'b0;
        bus.ld_addr = 5'd9;
        repeat (2) tick();
        bus.ld_req = 1'b0;
        tick_until_mode(M_RUN, "resume_after_halt");

        // loader request mid-instruction, four writes, then resume
        tick_until_exec_phase(2, "ld_ph2");
        bus.ld_req = 1'b1;
        bus.ld_we = 1'b1;
        tick_until_mode(M_LOAD, "ld_grant");
        for (int i = 0; i < 4; i++) begin
            bus.ld_addr = 5'(i);
            bus.ld_wdata = 8'hA0 + 8'(i);
            tick();
        end
        bus.ld_req = 1'b0;
        repeat (3) tick();

        // core access gating in IDLE versus RUN
        bus.run = 1'b0;
        tick_until_mode(M_IDLE, "gate_idle");
        bus.cpu_rd = 1'b1;
        bus.cpu_wr = 1'b1;
        bus.cpu_addr = 5'd17;
        bus.cpu_wdata = 8'h5C;
        repeat (3) tick();
        bus.run = 1'b1;
        repeat (5) tick();
        bus.cpu_rd = 1'b0;
        repeat (2) tick();
        bus.cpu_wr = 1'b0;

        // asynchronous reset mid-instruction and mid-load
        tick_until_exec_phase(5, "rst_ph5");
        async_reset("rst_run");
        bus.run = 1'b0;
        tick_until_mode(M_IDLE, "rst_idle");
        bus.ld_req = 1'b1;
        tick_until_mode(M_LOAD, "rst_load");
        tick();
        async_reset("rst_load");
        repeat (2) tick();

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 15) == 0) bus.run = ~bus.run;
            bus.step = ($urandom_range(0, 3) == 0);
            bus.halt = ($urandom_range(0, 24) == 0);
            bus.cpu_rd = $urandom_range(0, 1) == 1;
            bus.cpu_wr = $urandom_range(0, 1) == 1;
            bus.cpu_addr = 5'($urandom);
            bus.cpu_wdata = 8'($urandom);
            if (!bus.ld_req)
                bus.ld_req = ($urandom_range(0, 29) == 0);
            else if (m_mode == M_LOAD && $urandom_range(0, 3) == 0)
                bus.ld_req = 1'b0;
            bus.ld_we = $urandom_range(0, 1) == 1;
            bus.ld_addr = 5'($urandom);
            bus.ld_wdata = 8'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Run-control and memory-sharing sequencer for the VeriRISC core. It generates the 3-bit `phase` that drives `controller`, and freezes the core on `HLT`. It supports free-run and single-instruction step modes. It also shares the single program/data memory between the core and an external program loader, granting the loader only at instruction boundaries.

## Interface
- `AWIDTH`, 5, memory address width
- `DWIDTH`, 8, memory data width

- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `run`  in  1  level; 1 = free-run instructions
- `step`  in  1  rising edge requests one instruction
- `halt`  in  1  from `controller`; HLT decoded
- `cpu_addr`  in  AWIDTH  core memory address (mux output from `sel`)
- `cpu_wdata`  in  DWIDTH  core write data
- `cpu_rd`, `cpu_wr`  in  1 each  core memory strobes
- `ld_req`  in  1  loader requests memory
- `ld_we`  in  1  loader write (1) / read (0)
- `ld_addr`  in  AWIDTH  loader address
- `ld_wdata`  in  DWIDTH  loader write data
- `phase`  out  3  instruction phase to `controller`
- `cpu_en`  out  1  enable for PC/IR/AC registers and phase advance
- `ld_gnt`  out  1  loader owns memory
- `halted`  out  1  core stopped on HLT
- `busy`  out  1  instruction in progress (RUN or STEP)
- `mem_addr`  out  AWIDTH  to memory
- `mem_wdata`  out  DWIDTH  to memory
- `mem_rd`, `mem_wr`  out  1 each  to memory; never both high

## Operation
- FSM states: IDLE, RUN, STEP, HALTED, LOAD. Encoding is free.
- `cpu_en` = `busy` = state in {RUN, STEP}; `halted` = state HALTED; `ld_gnt` = state LOAD. All are decoded from the registered state.
- `phase` is a register:
  - 0 outside RUN/STEP.
  - In RUN/STEP it increments by 1 each cycle, wrapping 7→0.
- Instruction boundary is the cycle with `phase`=7 while `cpu_en`=1.
- `halt_seen` is set when `cpu_en` & `halt` (including in the phase-7 cycle). It is cleared on entry to HALTED or IDLE.
- `step_edge` = `step` & ~`step_q`. `step_q` is a register that updates every cycle.
- IDLE, priority order:
  - `ld_req` → LOAD
  - else `run` → RUN
  - else `step_edge` → STEP
- RUN at boundary, priority order:
  - `halt_seen`|`halt` → HALTED
  - else `ld_req` → LOAD
  - else ~`run` → IDLE
  - else stay in RUN; `phase` wraps to 0, so instructions run back-to-back with no bubble.
- STEP at boundary: `halt_seen`|`halt` → HALTED, else → IDLE. `run`, `step` and `ld_req` are ignored during STEP.
- HALTED: `ld_req` → LOAD; otherwise stay. Only reset or a load leaves HALTED.
- LOAD: ~`ld_req` → IDLE.
- Memory mux:
  - In LOAD: `mem_addr`=`ld_addr`, `mem_wdata`=`ld_wdata`, `mem_wr`=`ld_req`&`ld_we`, `mem_rd`=`ld_req`&~`ld_we`.
  - Otherwise: `cpu_*` passed through with `mem_rd`=`cpu_rd`&`cpu_en`, `mem_wr`=`cpu_wr`&`cpu_en`&~`cpu_rd`.
- The loader reads data from the shared memory read bus. The sequencer does not register it.

## Timing
- Reset, asynchronous: state IDLE, `phase`=0, `step_q`=0, `halt_seen`=0.
  - Hence `cpu_en`=`busy`=`halted`=`ld_gnt`=0 and `mem_rd`=`mem_wr`=0.
  - Reset mid-instruction or mid-load aborts immediately. No completion is guaranteed.
- Start latency: `run` sampled high in IDLE at edge N. State is RUN with `phase`=0 after edge N; `phase`=7 after edge N+7.
- Instruction length is exactly 8 cycles.
- Dropping `run` mid-instruction completes the current instruction, then enters IDLE.
- Grant latency:
  - From IDLE or HALTED: 1 cycle after `ld_req` is sampled.
  - From RUN: the cycle after the boundary.
- The loader must hold `ld_req` until `ld_gnt`. Each cycle with `ld_gnt`&`ld_req` is one memory access.
- After `ld_req` falls, `ld_gnt` falls 1 cycle later. The memory strobes are already 0 in that cycle.
- Simultaneous events:
  - `ld_req`+`run` in IDLE → LOAD.
  - `run`+`step_edge` → RUN.
  - `halt`+`ld_req` at boundary → HALTED; the load is granted next cycle from HALTED.
- A `step` rising edge outside IDLE is lost, not queued.

## Test plan
- Reset, then `run`=1 for 24 cycles → `phase` sequence 0..7 three times; `cpu_en`=1 from cycle 1; no gap at wrap.
- In IDLE, pulse `step` once, with `step` held high for 20 cycles → exactly one 8-cycle instruction, then IDLE with `busy`=0. A second `step` rising edge → one more instruction.
- RUN with `halt`=1 at `phase`=3 → `phase` continues to 7, then `halted`=1, `phase`=0, `cpu_en`=0. `run` toggling has no effect until `ld_req`.
- `ld_req` raised at RUN `phase`=2 → `ld_gnt` rises the cycle after `phase`=7.
  - Then 4 writes: `ld_addr` 0..3, `ld_wdata` 8'hA0..8'hA3 → `mem_wr`=1 for 4 cycles with matching address/data.
  - Drop `ld_req` → IDLE, then RUN resumes since `run`=1.
- Core access gating: `cpu_rd`=`cpu_wr`=1 while IDLE → `mem_rd`=`mem_wr`=0; in RUN → only `mem_rd`=1.
- Assert `rst_n`=0 at `phase`=5 and again during LOAD → all outputs go to reset values immediately, without waiting for a clock edge.
